// File: rtl/plt_collision_scan.sv
// Sequential one-way platform landing detector: scans a configurable platform
// table one entry per clock and reports the highest crossed surface.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; table writes accepted
// S_SCAN | evaluating entry idx against the latched character position
// S_DONE | publishing best-hit registers, done pulses on the next cycle
module plt_collision_scan #(
    parameter int NUM_PLT = 3,
    parameter int WIDTH   = 23,
    parameter int HEIGHT  = 30,
    parameter int SCALE   = 2,
    parameter logic [NUM_PLT*11-1:0] PLT_X_INIT = {11'd210, 11'd30, 11'd120},
    parameter logic [NUM_PLT*11-1:0] PLT_Y_INIT = {11'd140, 11'd140, 11'd215},
    parameter logic [NUM_PLT*11-1:0] PLT_W_INIT = {11'd80, 11'd80, 11'd105},
    parameter logic [NUM_PLT-1:0]    PLT_SOLID_INIT = 3'b001,
    localparam int IW = (NUM_PLT > 1) ? $clog2(NUM_PLT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [10:0]   x_pos,
    input  logic [10:0]   y_pos,
    input  logic [10:0]   next_y,
    input  logic          drop_through,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [10:0]   cfg_x,
    input  logic [10:0]   cfg_y,
    input  logic [10:0]   cfg_w,
    input  logic          cfg_solid,
    output logic          busy,
    output logic          done,
    output logic          landed,
    output logic [IW-1:0] plt_idx,
    output logic [10:0]   snap_y
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic signed [11:0] H12      = 12'(HEIGHT * SCALE);
    localparam logic signed [11:0] W12      = 12'(WIDTH * SCALE);
    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_PLT - 1);
    localparam logic [IW:0]        NUM_L    = (IW + 1)'(NUM_PLT);

    function automatic logic signed [11:0] sx(input logic [10:0] v);
        return $signed({v[10], v});
    endfunction

    state_t        state, state_nx;
    logic [IW-1:0] idx;

    logic [10:0]   lx, ly, lny;
    logic          ldrop;

    logic [10:0]   tx [NUM_PLT];
    logic [10:0]   ty [NUM_PLT];
    logic [10:0]   tw [NUM_PLT];
    logic [NUM_PLT-1:0] tsolid;

    logic          best_hit;
    logic [IW-1:0] best_idx;
    logic [10:0]   best_py;

    logic          hit, eligible, better, cfg_ok;
    logic signed [11:0] snap_full;

    assign busy   = (state != S_IDLE) || done;
    assign cfg_ok = cfg_we && !busy && ({1'b0, cfg_idx} < NUM_L);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && !busy) state_nx = S_SCAN;
            S_SCAN:  if (idx == LAST_IDX) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        hit = (sx(ly) + H12 <= sx(ty[idx]))
           && (sx(lny) + H12 >= sx(ty[idx]))
           && (sx(lx) + W12 >= sx(tx[idx]))
           && (sx(lx) <= sx(tx[idx]) + sx(tw[idx]));
        eligible  = hit && (tsolid[idx] || !ldrop);
        better    = !best_hit || (sx(ty[idx]) < sx(best_py));
        snap_full = sx(best_py) - H12;
    end

    // Platform table; reset restores the build-time layout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PLT; i++) begin
                tx[i] <= PLT_X_INIT[i*11 +: 11];
                ty[i] <= PLT_Y_INIT[i*11 +: 11];
                tw[i] <= PLT_W_INIT[i*11 +: 11];
            end
            tsolid <= PLT_SOLID_INIT;
        end else if (cfg_ok) begin
            tx[cfg_idx]     <= cfg_x;
            ty[cfg_idx]     <= cfg_y;
            tw[cfg_idx]     <= cfg_w;
            tsolid[cfg_idx] <= cfg_solid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            lx       <= '0;
            ly       <= '0;
            lny      <= '0;
            ldrop    <= 1'b0;
            best_hit <= 1'b0;
            best_idx <= '0;
            best_py  <= '0;
            done     <= 1'b0;
            landed   <= 1'b0;
            plt_idx  <= '0;
            snap_y   <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !busy) begin
                        lx       <= x_pos;
                        ly       <= y_pos;
                        lny      <= next_y;
                        ldrop    <= drop_through;
                        best_hit <= 1'b0;
                        best_idx <= '0;
                        best_py  <= '0;
                        idx      <= '0;
                    end
                end
                S_SCAN: begin
                    // Ties keep the earlier entry: only a strictly higher surface replaces it.
                    if (eligible && better) begin
                        best_hit <= 1'b1;
                        best_idx <= idx;
                        best_py  <= ty[idx];
                    end
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    landed  <= best_hit;
                    plt_idx <= best_hit ? best_idx : '0;
                    snap_y  <= best_hit ? snap_full[10:0] : 11'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_plt_collision_scan.sv
// Bench for plt_collision_scan: directed landing cases plus randomized scans
// and table writes checked against a table-level landing model.
module tb_plt_collision_scan;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int H  = 60;
    localparam int W  = 46;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [10:0]   x_pos = '0, y_pos = '0, next_y = '0;
    logic          drop_through = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [10:0]   cfg_x = '0, cfg_y = '0, cfg_w = '0;
    logic          cfg_solid = 1'b0;
    logic          busy, done, landed;
    logic [IW-1:0] plt_idx;
    logic [10:0]   snap_y;

    plt_collision_scan dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_pos(x_pos), .y_pos(y_pos), .next_y(next_y), .drop_through(drop_through),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_w(cfg_w), .cfg_solid(cfg_solid),
        .busy(busy), .done(done), .landed(landed), .plt_idx(plt_idx), .snap_y(snap_y)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mx [N];
    int my [N];
    int mw [N];
    int ms [N];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int s11(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        mx = '{120, 30, 210};
        my = '{215, 140, 140};
        mw = '{105, 80, 80};
        ms = '{1, 0, 0};
    endtask

    // Eligible platforms first, then highest surface, then lowest index among equals.
    task automatic model(input logic [10:0] xv, yv, nyv, input bit drop,
                         output int el, output int ei, output int es);
        int x, y, ny, minpy;
        bit elig [N];
        bit any;
        x = s11(xv); y = s11(yv); ny = s11(nyv);
        any = 0; minpy = 0;
        for (int i = 0; i < N; i++) begin
            elig[i] = (y + H <= my[i]) && (ny + H >= my[i]) && (x + W >= mx[i])
                   && (x <= mx[i] + mw[i]) && (ms[i] == 1 || !drop);
            if (elig[i] && (!any || my[i] < minpy)) minpy = my[i];
            if (elig[i]) any = 1;
        end
        el = any ? 1 : 0;
        ei = 0;
        es = any ? ((minpy - H) & 'h7FF) : 0;
        if (any) begin
            for (int i = N - 1; i >= 0; i--)
                if (elig[i] && my[i] == minpy) ei = i;
        end
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int w, input bit s);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = IW'(idx);
        cfg_x = 11'(x); cfg_y = 11'(y); cfg_w = 11'(w); cfg_solid = s;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < N) begin
            mx[idx] = s11(11'(x)); my[idx] = s11(11'(y));
            mw[idx] = s11(11'(w)); ms[idx] = s;
        end
    endtask

    task automatic run_scan(input logic [10:0] x, y, ny, input bit drop,
                            output int gl, output int gi, output int gs);
        int k;
        bit seen;
        @(negedge clk);
        x_pos = x; y_pos = y; next_y = ny; drop_through = drop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_pos = 11'($urandom); y_pos = 11'($urandom); next_y = 11'($urandom);
        drop_through = 1'($urandom);
        chk("busy_after_start", int'(busy), 1);
        k = 1; seen = 0;
        while (!seen && k < 20) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("latency", seen ? k : -1, N + 2);
        chk("busy_at_done", int'(busy), 1);
        gl = int'(landed); gi = int'(plt_idx); gs = int'(snap_y);
        @(negedge clk);
        chk("done_single", int'(done), 0);
        chk("busy_clear", int'(busy), 0);
        chk("result_hold", int'(landed), gl);
    endtask

    task automatic scan_check(input string tag, input logic [10:0] x, y, ny, input bit drop,
                              output int gl, output int gi, output int gs);
        int el, ei, es;
        model(x, y, ny, drop, el, ei, es);
        run_scan(x, y, ny, drop, gl, gi, gs);
        chk({tag, "_landed"}, gl, el);
        chk({tag, "_idx"}, gi, ei);
        chk({tag, "_snap"}, gs, es);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int gl, gi, gs, cnt;
        logic [10:0] rx, ry, rny;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_landed", int'(landed), 0);
        chk("rst_idx", int'(plt_idx), 0);
        chk("rst_snap", int'(snap_y), 0);
        rst_n = 1'b1;
        @(negedge clk);

        scan_check("t1", 150, 150, 160, 0, gl, gi, gs);
        chk("t1_c_landed", gl, 1); chk("t1_c_idx", gi, 0); chk("t1_c_snap", gs, 155);
        scan_check("t2", 50, 75, 85, 0, gl, gi, gs);
        chk("t2_c_landed", gl, 1); chk("t2_c_idx", gi, 1); chk("t2_c_snap", gs, 80);
        scan_check("t2d", 50, 75, 85, 1, gl, gi, gs);
        chk("t2d_c_landed", gl, 0); chk("t2d_c_snap", gs, 0);
        scan_check("t1d", 150, 150, 160, 1, gl, gi, gs);
        chk("t1d_c_landed", gl, 1); chk("t1d_c_idx", gi, 0);

        scan_check("e74", 74, 150, 160, 0, gl, gi, gs);  chk("e74_c", gl, 1);
        scan_check("e73", 73, 150, 160, 0, gl, gi, gs);  chk("e73_c", gl, 0);
        scan_check("e225", 225, 150, 160, 0, gl, gi, gs); chk("e225_c", gl, 1);
        scan_check("e226", 226, 150, 160, 0, gl, gi, gs); chk("e226_c", gl, 0);
        scan_check("eflat", 150, 155, 155, 0, gl, gi, gs);
        chk("eflat_c", gl, 1); chk("eflat_c_snap", gs, 155);

        // start and cfg_we while busy must both be dropped
        @(negedge clk);
        x_pos = 150; y_pos = 150; next_y = 160; drop_through = 0; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 0; cfg_x = 120; cfg_y = 100; cfg_w = 105; cfg_solid = 1;
        x_pos = 50; y_pos = 75; next_y = 85;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                cnt++;
                chk("busy_scan_snap", int'(snap_y), 155);
            end
            @(negedge clk);
        end
        chk("busy_one_done", cnt, 1);
        scan_check("busy_t1", 150, 150, 160, 0, gl, gi, gs);
        chk("busy_t1_c_snap", gs, 155);

        // reset mid-scan after modifying the table
        cfg_write(0, 120, 100, 105, 1);
        @(negedge clk);
        x_pos = 150; y_pos = 150; next_y = 160; drop_through = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_landed", int'(landed), 0);
        chk("mid_rst_snap", int'(snap_y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("mid_rst_no_done", cnt, 0);
        scan_check("rst_t1", 150, 150, 160, 0, gl, gi, gs);
        chk("rst_t1_c_landed", gl, 1); chk("rst_t1_c_snap", gs, 155);

        cfg_write(2, 120, 200, 105, 0);
        scan_check("prio", 150, 140, 160, 0, gl, gi, gs);
        chk("prio_c_idx", gi, 2); chk("prio_c_snap", gs, 140);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write($urandom_range(0, 3), $urandom_range(0, 300), $urandom_range(60, 260),
                          $urandom_range(0, 150), 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                rx = 11'($urandom); ry = 11'($urandom); rny = 11'($urandom);
            end else begin
                rx  = 11'($urandom_range(0, 300));
                ry  = 11'($urandom_range(0, 220));
                rny = 11'(int'(ry) + $urandom_range(0, 60) - 10);
            end
            scan_check("rand", rx, ry, rny, 1'($urandom), gl, gi, gs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plt_collision_scan.md
# plt_collision_scan

Multi-platform landing detector for the physics stage. Once per frame it scans a run-time-configurable table of `NUM_PLT` one-way platforms, one entry per clock, against a character's current and next position. It reports whether the character lands, on which platform, and the Y value to snap to. It sits between the character position integrator and the Y-position register, replacing the per-platform combinational checks with one shared, sequential comparator.

## Interface
- `NUM_PLT`, 3: number of platform table entries (1..16).
- `WIDTH`, 23: character sprite width in unscaled pixels.
- `HEIGHT`, 30: character sprite height in unscaled pixels.
- `SCALE`, 2: sprite scale factor applied to `WIDTH` and `HEIGHT`.
- `PLT_X_INIT`, {11'd210, 11'd30, 11'd120}: packed reset X (left edge) per entry, entry 0 in the LSBs.
- `PLT_Y_INIT`, {11'd140, 11'd140, 11'd215}: packed reset Y (top surface) per entry.
- `PLT_W_INIT`, {11'd80, 11'd80, 11'd105}: packed reset width per entry.
- `PLT_SOLID_INIT`, 3'b001: reset solid flag per entry; solid platforms cannot be dropped through.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame pulse that begins a scan.
- `x_pos`  in  11 signed  character left edge.
- `y_pos`  in  11 signed  character top, current frame.
- `next_y`  in  11 signed  character top, proposed next frame.
- `drop_through`  in  1  character requests to fall through non-solid platforms.
- `cfg_we`  in  1  platform table write strobe.
- `cfg_idx`  in  $clog2(NUM_PLT) (min 1)  entry to write.
- `cfg_x`, `cfg_y`, `cfg_w`  in  11 each  new entry geometry.
- `cfg_solid`  in  1  new entry solid flag.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `landed`  out  1  a platform was crossed this frame.
- `plt_idx`  out  $clog2(NUM_PLT) (min 1)  selected platform index.
- `snap_y`  out  11 signed  `PLT_Y - HEIGHT*SCALE` of the selected platform.

## Operation
- Table: `NUM_PLT` registered entries {x, y, w, solid}, reset to the `*_INIT` values. A write with `cfg_we=1` while `busy=0` updates entry `cfg_idx` at the clock edge. Writes while busy, or with `cfg_idx >= NUM_PLT`, are dropped.
- FSM states:
  - IDLE: on `start`, latch `x_pos`, `y_pos`, `next_y` and `drop_through`; clear the best-hit registers; go to SCAN with idx=0.
  - SCAN: evaluate entry idx; if idx=NUM_PLT-1 go to DONE, else idx+1.
  - DONE: pulse `done`; drive `landed`, `plt_idx` and `snap_y` from the best-hit registers; return to IDLE.
- Hit test for entry i, using latched inputs, with H=HEIGHT*SCALE and W=WIDTH*SCALE. All four terms must hold:
  - `y+H <= Py`
  - `ny+H >= Py`
  - `x+W >= Px`
  - `x <= Px+Pw`
- Eligibility: a hit counts only if `solid=1` or latched `drop_through=0`.
- Selection among eligible hits: smallest Py (highest surface) wins. On equal Py, the lower index wins; a later entry replaces the best only if its Py is strictly smaller.
- Arithmetic: sign-extend all operands to 12 bits before add/compare, so no wrap occurs at 11-bit extremes. `snap_y` is truncated to 11 bits.
- `start` while busy is ignored. Inputs change freely after the latch cycle.

## Timing
- Reset values: `busy=0`, `done=0`, `landed=0`, `plt_idx=0`, `snap_y=0`, FSM=IDLE, table=INIT.
- Latency: `start` is sampled at edge 0; SCAN occupies edges 1..NUM_PLT; `done=1` in the cycle after edge NUM_PLT+1 (NUM_PLT+2 cycles start-to-done).
- `busy` is high from the cycle after `start` through the `done` cycle inclusive.
- `landed`, `plt_idx` and `snap_y` update only at DONE and hold until the next DONE. If there is no hit, DONE drives `landed=0`, `plt_idx=0`, `snap_y=0`.
- `rst_n` low mid-scan: immediate return to IDLE, all outputs to reset values, table to INIT, no `done` pulse.

## Test plan
- Land on entry 0: x=150, y=150, next_y=160, drop_through=0, pulse start -> 5 cycles later `done=1`, `landed=1`, `plt_idx=0`, `snap_y=155`.
- Non-solid drop: x=50, y=75, next_y=85 -> `landed=1`, `plt_idx=1`, `snap_y=80`. Repeat with drop_through=1 -> `landed=0`. Repeat test 1 with drop_through=1 -> still `landed=1`, `plt_idx=0`.
- Priority: write entry 2 = (120, 200, 105, solid=0); x=150, y=140, next_y=160 -> entries 0 and 2 both hit -> `plt_idx=2`, `snap_y=140`.
- Edges: x=74 (x+46=120) with y=150, next_y=160 -> hit. x=73 -> miss. x=225 -> hit. x=226 -> miss. y=155, next_y=155 -> hit (bottom equals surface on both frames).
- Busy rules: `start` and `cfg_we` (entry 0, y=100) asserted while busy -> scan unaffected, no second `done`, and entry 0 still lands at `snap_y=155` on the next scan.
- Reset: assert `rst_n=0` on the second SCAN cycle -> `busy=0`, `landed=0`, no `done`, and the table restored to INIT (verified by rerunning test 1).
